// File: rtl/uart_xcvr_param_pkg.sv
// Shared definitions for the parametrised UART transceiver: parity modes,
// TX/RX state encodings and the baud divider calculation.
// Imported by the baud tick generator and the transceiver top.
package uart_xcvr_param_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   // Clocks per oversample tick, rounded to nearest and never below one.
   function automatic int calc_div(input int clk_freq, input int baud, input int os);
      int den;
      int d;
      den = baud * os;
      d   = (clk_freq + den / 2) / den;
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_xcvr_param_if.sv
// Host-side bus of the UART transceiver: TX request/status and RX result/flags.
// master = host (drives tx_start/tx_data), slave = transceiver.
// tx_start is a request, not a handshake: it is dropped while tx_busy is high.
interface uart_xcvr_param_if #(
   parameter int DATA_BITS = 8
) ();
   logic                 tx_start;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_busy;
   logic                 tx_done;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_done;
   logic                 rx_parity_err;
   logic                 rx_frame_err;

   modport master (
      output tx_start, tx_data,
      input  tx_busy, tx_done, rx_data, rx_done, rx_parity_err, rx_frame_err
   );

   modport slave (
      input  tx_start, tx_data,
      output tx_busy, tx_done, rx_data, rx_done, rx_parity_err, rx_frame_err
   );
endinterface

// File: rtl/uart_xcvr_param_baud_tick.sv
// Purpose: free-running divider producing one oversample tick every DIV clocks.
// Latency: tick is a decode of the counter register, no pipeline.
// Backpressure: none, always running.
// Ports: i_clk, i_rst_n (async active-low), o_tick (1-cycle pulse per oversample period).
module uart_xcvr_param_baud_tick #(
   parameter int DIV = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign o_tick = (r_cnt == CW'(DIV - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/uart_xcvr_param.sv
// Purpose: full-duplex UART, configurable width/parity/stop bits, 16x-style oversampled RX.
// Latency: TX line changes one clk after acceptance; RX flags/data appear one clk after stop sample.
// Backpressure: tx_start ignored while tx_busy; RX has no backpressure (rx_data overwritten per frame).
// Ports: i_clk, i_rst_n (async active-low), io_bus (host bus, slave side), o_tx serial out, i_rx serial in.
module uart_xcvr_param
   import uart_xcvr_param_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = PAR_NONE,
   parameter int STOP_BITS  = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   uart_xcvr_param_if.slave     io_bus,
   output logic                 o_tx,
   input  logic                 i_rx
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int OSW = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
   localparam logic [OSW-1:0] OS_HALF   = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

   logic w_tick;

   uart_xcvr_param_baud_tick #(.DIV(DIV)) u_baud (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .o_tick  (w_tick)
   );

   // ---------------------------------------------------------------- TX
   tx_state_t            r_tx_state, w_tx_nxt_state;
   logic                 r_tx, w_tx_nxt;
   logic                 r_tx_done;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 r_tx_par;
   logic [OSW-1:0]       r_tx_os;
   logic [BW-1:0]        r_tx_cnt;
   logic                 r_tx_stop;
   logic                 w_tx_load, w_tx_fin, w_tx_bit_end;

   assign w_tx_bit_end = w_tick && (r_tx_os == OS_LAST);

   // Next line level is decided together with the next state so o_tx is a
   // plain register and changes exactly on bit boundaries.
   always_comb begin
      w_tx_nxt_state = r_tx_state;
      w_tx_nxt       = r_tx;
      w_tx_load      = 1'b0;
      w_tx_fin       = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_nxt = 1'b1;
            if (io_bus.tx_start) begin
               w_tx_load      = 1'b1;
               w_tx_nxt_state = TX_START;
               w_tx_nxt       = 1'b0;
            end
         end
         TX_START: begin
            if (w_tx_bit_end) begin
               w_tx_nxt_state = TX_DATA;
               w_tx_nxt       = r_tx_shift[0];
            end
         end
         TX_DATA: begin
            if (w_tx_bit_end) begin
               if (r_tx_cnt == BIT_LAST) begin
                  if (PARITY != PAR_NONE) begin
                     w_tx_nxt_state = TX_PARITY;
                     w_tx_nxt       = r_tx_par;
                  end else begin
                     w_tx_nxt_state = TX_STOP;
                     w_tx_nxt       = 1'b1;
                  end
               end else begin
                  w_tx_nxt = r_tx_shift[1];
               end
            end
         end
         TX_PARITY: begin
            if (w_tx_bit_end) begin
               w_tx_nxt_state = TX_STOP;
               w_tx_nxt       = 1'b1;
            end
         end
         TX_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_tx_bit_end && (r_tx_stop == STOP_LAST)) begin
               w_tx_nxt_state = TX_IDLE;
               w_tx_fin       = 1'b1;
            end
         end
         default: begin
            w_tx_nxt_state = TX_IDLE;
            w_tx_nxt       = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_state <= TX_IDLE;
         r_tx       <= 1'b1;
         r_tx_done  <= 1'b0;
      end else begin
         r_tx_state <= w_tx_nxt_state;
         r_tx       <= w_tx_nxt;
         r_tx_done  <= w_tx_fin;
      end
   end

   // Bit timer restarts on acceptance so the start bit is a full period.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
         r_tx_os    <= '0;
         r_tx_cnt   <= '0;
         r_tx_stop  <= 1'b0;
      end else if (w_tx_load) begin
         r_tx_shift <= io_bus.tx_data;
         r_tx_par   <= (PARITY == PAR_ODD) ? ~^io_bus.tx_data : ^io_bus.tx_data;
         r_tx_os    <= '0;
         r_tx_cnt   <= '0;
         r_tx_stop  <= 1'b0;
      end else begin
         if (w_tx_bit_end) begin
            r_tx_os <= '0;
         end else if (w_tick && (r_tx_state != TX_IDLE)) begin
            r_tx_os <= r_tx_os + 1'b1;
         end
         if ((r_tx_state == TX_DATA) && w_tx_bit_end) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_cnt   <= r_tx_cnt + 1'b1;
         end
         if ((r_tx_state == TX_STOP) && w_tx_bit_end) begin
            r_tx_stop <= r_tx_stop + 1'b1;
         end
      end
   end

   assign o_tx           = r_tx;
   assign io_bus.tx_busy = (r_tx_state != TX_IDLE);
   assign io_bus.tx_done = r_tx_done;

   // ---------------------------------------------------------------- RX
   rx_state_t            r_rx_state, w_rx_nxt_state;
   logic                 r_rx_s1, r_rx_s2, r_rx_s3;
   logic [OSW-1:0]       r_rx_os;
   logic [BW-1:0]        r_rx_cnt;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic                 r_rx_par_bit;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_done, r_rx_perr, r_rx_ferr;
   logic                 w_rx, w_rx_fall, w_rx_mid, w_rx_start, w_rx_fin, w_rx_perr;

   assign w_rx      = r_rx_s2;
   assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
   // Start bit is checked half a bit in; every later sample is one full bit on,
   // which lands each sample near mid-bit.
   assign w_rx_mid  = w_tick && (r_rx_os == ((r_rx_state == RX_START) ? OS_HALF : OS_LAST));
   assign w_rx_perr = (PARITY == PAR_EVEN) ? (^r_rx_shift ^ r_rx_par_bit) :
                      (PARITY == PAR_ODD)  ? ~(^r_rx_shift ^ r_rx_par_bit) : 1'b0;

   always_comb begin
      w_rx_nxt_state = r_rx_state;
      w_rx_start     = 1'b0;
      w_rx_fin       = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            if (w_rx_fall) begin
               w_rx_nxt_state = RX_START;
               w_rx_start     = 1'b1;
            end
         end
         RX_START: begin
            if (w_rx_mid) w_rx_nxt_state = w_rx ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (w_rx_mid && (r_rx_cnt == BIT_LAST)) begin
               w_rx_nxt_state = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
         end
         RX_PARITY: begin
            if (w_rx_mid) w_rx_nxt_state = RX_STOP;
         end
         RX_STOP: begin
            if (w_rx_mid) begin
               w_rx_fin       = 1'b1;
               w_rx_nxt_state = w_rx ? RX_IDLE : RX_WAIT_HIGH;
            end
         end
         RX_WAIT_HIGH: begin
            // Line held low (break): stay until a bit sample sees it high.
            if (w_rx_mid && w_rx) w_rx_nxt_state = RX_IDLE;
         end
         default: w_rx_nxt_state = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_state <= RX_IDLE;
      end else begin
         r_rx_state <= w_rx_nxt_state;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_s1      <= 1'b1;
         r_rx_s2      <= 1'b1;
         r_rx_s3      <= 1'b1;
         r_rx_os      <= '0;
         r_rx_cnt     <= '0;
         r_rx_shift   <= '0;
         r_rx_par_bit <= 1'b0;
         r_rx_data    <= '0;
         r_rx_done    <= 1'b0;
         r_rx_perr    <= 1'b0;
         r_rx_ferr    <= 1'b0;
      end else begin
         r_rx_s1   <= i_rx;
         r_rx_s2   <= r_rx_s1;
         r_rx_s3   <= r_rx_s2;
         r_rx_done <= w_rx_fin;
         if (w_rx_start || w_rx_mid) begin
            r_rx_os <= '0;
         end else if (w_tick && (r_rx_state != RX_IDLE)) begin
            r_rx_os <= r_rx_os + 1'b1;
         end
         if (w_rx_start) begin
            r_rx_cnt <= '0;
         end
         if ((r_rx_state == RX_DATA) && w_rx_mid) begin
            r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
            r_rx_cnt   <= r_rx_cnt + 1'b1;
         end
         if ((r_rx_state == RX_PARITY) && w_rx_mid) begin
            r_rx_par_bit <= w_rx;
         end
         if (w_rx_fin) begin
            r_rx_data <= r_rx_shift;
            r_rx_perr <= w_rx_perr;
            r_rx_ferr <= ~w_rx;
         end
      end
   end

   assign io_bus.rx_data       = r_rx_data;
   assign io_bus.rx_done       = r_rx_done;
   assign io_bus.rx_parity_err = r_rx_perr;
   assign io_bus.rx_frame_err  = r_rx_ferr;

endmodule
